jt51_pm_keycode: RTL



---
 rtl/jt51_pm_keycode.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/jt51_pm_keycode.sv
// Per-slot LFO pitch modulation: scale PM by PMS, add in linear
// 1/64-semitone space, clamp, and re-encode to KC/KF (3-cycle pipeline).
module jt51_pm_keycode (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] in_slot,
    input  logic [6:0] kc,
    input  logic [5:0] kf,
    input  logic [2:0] pms,
    input  logic [7:0] pm_u,
    output logic       out_valid,
    output logic [4:0] out_slot,
    output logic [6:0] kc_out,
    output logic [5:0] kf_out,
    output logic       ovf
);

    localparam logic [13:0] LinMax = 14'd6143;

    // ---------------- stage 1: capture + scale ----------------
    logic [6:0] mag;
    logic [8:0] off_d;

    assign mag = pm_u[6:0];

    always_comb begin
        off_d = '0;
        unique case (pms)
            3'd0: off_d = '0;
            3'd1: off_d = {2'b00, mag >> 5};
            3'd2: off_d = {2'b00, mag >> 4};
            3'd3: off_d = {2'b00, mag >> 3};
            3'd4: off_d = {2'b00, mag >> 2};
            3'd5: off_d = {2'b00, mag >> 1};
            3'd6: off_d = {1'b0, mag, 1'b0};
            3'd7: off_d = {mag, 2'b00};
        endcase
    end

    logic       v1_q;
    logic [4:0] slot1_q;
    logic [6:0] kc1_q;
    logic [5:0] kf1_q;
    logic       byp1_q;
    logic       neg1_q;
    logic [8:0] off1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            slot1_q <= '0;
            kc1_q   <= '0;
            kf1_q   <= '0;
            byp1_q  <= 1'b0;
            neg1_q  <= 1'b0;
            off1_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                slot1_q <= in_slot;
                kc1_q   <= kc;
                kf1_q   <= kf;
                byp1_q  <= (pms == 3'd0);
                neg1_q  <= pm_u[7];
                off1_q  <= off_d;
            end
        end
    end

    // ---------------- stage 2: linearise + add + clamp ----------------
    logic [1:0]  note_lo;
    logic [3:0]  idx;
    logic [6:0]  semi_lin;
    logic [12:0] lin;
    logic [13:0] sum;
    logic [12:0] sum_c;
    logic        ovf_c;

    // Unused note code 3 folds onto 2 within each group of three.
    assign note_lo  = (kc1_q[1:0] == 2'd3) ? 2'd2 : kc1_q[1:0];
    assign idx      = {2'b00, kc1_q[3:2]} * 4'd3 + {2'b00, note_lo};
    assign semi_lin = {4'b0000, kc1_q[6:4]} * 7'd12 + {3'b000, idx};
    assign lin      = {semi_lin, kf1_q};
    assign sum      = neg1_q ? ({1'b0, lin} - {5'b00000, off1_q})
                             : ({1'b0, lin} + {5'b00000, off1_q});

    always_comb begin
        sum_c = sum[12:0];
        ovf_c = 1'b0;
        if (sum[13]) begin
            sum_c = '0;
            ovf_c = 1'b1;
        end else if (sum > LinMax) begin
            sum_c = LinMax[12:0];
            ovf_c = 1'b1;
        end
    end

    logic        v2_q;
    logic [4:0]  slot2_q;
    logic [12:0] sum2_q;
    logic        ovf2_q;
    logic        byp2_q;
    logic [6:0]  kc2_q;
    logic [5:0]  kf2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            slot2_q <= '0;
            sum2_q  <= '0;
            ovf2_q  <= 1'b0;
            byp2_q  <= 1'b0;
            kc2_q   <= '0;
            kf2_q   <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                slot2_q <= slot1_q;
                sum2_q  <= sum_c;
                ovf2_q  <= ovf_c & ~byp1_q;
                byp2_q  <= byp1_q;
                kc2_q   <= kc1_q;
                kf2_q   <= kf1_q;
            end
        end
    end

    // ---------------- stage 3: re-encode ----------------
    logic [6:0] semis;
    logic [2:0] oct;
    logic [3:0] rem;
    logic [6:0] kc_d;
    logic [5:0] kf_d;

    assign semis = sum2_q[12:6];
    assign oct   = 3'(semis / 7'd12);
    assign rem   = 4'(semis % 7'd12);

    always_comb begin
        kc_d = {oct, 2'(rem / 4'd3), 2'(rem % 4'd3)};
        kf_d = sum2_q[5:0];
        if (byp2_q) begin
            kc_d = kc2_q;
            kf_d = kf2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_slot  <= '0;
            kc_out    <= '0;
            kf_out    <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                out_slot <= slot2_q;
                kc_out   <= kc_d;
                kf_out   <= kf_d;
                ovf      <= ovf2_q;
            end
        end
    end

endmodule
